dmem_arbiter: RTL and testbench

Two-master arbiter for the unified memory's data port. It shares the single D-port (addr/wen/wdata in, rdata out one cycle later) between the core's load/store unit and the hex loader/debug master. Each cycle it grants at most one request, drives the port combinationally, and registers which master owns the pending read so that `rdata` is routed back on the following cycle. The loader normally has priority; a starvation counter guarantees the core forward progress.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 80 ++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-port arbiter.
// WORD_LEN and ARB_STARVE_LIMIT carry the values previously supplied by consts.vh.
package dmem_arbiter_pkg;

    localparam int unsigned WORD_LEN         = 32;
    localparam int unsigned ARB_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CORE = 2'd1,
        GNT_LDR  = 2'd2
    } grant_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's view of the shared data port: request, zero-latency grant,
// and a registered read-valid qualifying the passthrough read data.
interface dmem_arbiter_if;

    logic                                 req;
    logic [dmem_arbiter_pkg::WORD_LEN-1:0] addr;
    logic                                 wen;
    logic [dmem_arbiter_pkg::WORD_LEN-1:0] wdata;
    logic                                 gnt;
    logic                                 rvalid;
    logic [dmem_arbiter_pkg::WORD_LEN-1:0] rdata;

    modport master (
        output req, addr, wen, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, wen, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the unified memory data port: loader-priority grant
// with a starvation counter, combinational port mux and registered read routing.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    dmem_arbiter_if.slave       core,
    dmem_arbiter_if.slave       ldr,
    output logic [WORD_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [WORD_LEN-1:0] mem_wdata,
    input  logic [WORD_LEN-1:0] mem_rdata
);

    grant_e             w_grant;
    logic               w_at_limit;
    logic               r_resp_core;
    logic               r_resp_ldr;
    logic [CNT_W-1:0]   r_starve_cnt;

    assign w_at_limit = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

    // Loader wins contention unless the core has been passed over STARVE_LIMIT times.
    always_comb begin
        w_grant = GNT_NONE;
        if (ldr.req && !(core.req && w_at_limit)) begin
            w_grant = GNT_LDR;
        end else if (core.req) begin
            w_grant = GNT_CORE;
        end
    end

    assign core.gnt = (w_grant == GNT_CORE);
    assign ldr.gnt  = (w_grant == GNT_LDR);

    always_comb begin
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        case (w_grant)
            GNT_CORE: begin
                mem_addr  = core.addr;
                mem_wen   = core.wen;
                mem_wdata = core.wdata;
            end
            GNT_LDR: begin
                mem_addr  = ldr.addr;
                mem_wen   = ldr.wen;
                mem_wdata = ldr.wdata;
            end
            default: ;
        endcase
    end

    assign core.rvalid = r_resp_core;
    assign ldr.rvalid  = r_resp_ldr;
    assign core.rdata  = mem_rdata;
    assign ldr.rdata   = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_core  <= 1'b0;
            r_resp_ldr   <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_resp_core <= core.gnt & ~core.wen;
            r_resp_ldr  <= ldr.gnt & ~ldr.wen;
            if (w_grant == GNT_CORE || !core.req) begin
                r_starve_cnt <= '0;
            end else if (w_grant == GNT_LDR && !w_at_limit) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed checks of dmem_arbiter against a behavioural model
// (shadow memory, expected-response slots, contested-loss counter).
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    dmem_arbiter_if core_if ();
    dmem_arbiter_if ldr_if ();

    dmem_arbiter #(
        .STARVE_LIMIT (LIMIT),
        .CNT_W        (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .core      (core_if.slave),
        .ldr       (ldr_if.slave),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory device: synchronous write, one-cycle registered read.
    logic [31:0] tbmem [64];
    always @(posedge clk) begin
        if (mem_wen) tbmem[mem_addr[7:2]] <= mem_wdata;
        mem_rdata <= tbmem[mem_addr[7:2]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;

    logic [31:0] shadow [64];
    logic        m_cv, m_lv;
    logic [31:0] m_cd, m_ld;
    int          m_starve;
    logic        last_gc, last_gl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check one cycle against the model, advance the model, then cross the clock edge.
    task automatic tick();
        logic both, eg_c, eg_l;
        #1;
        both = core_if.req && ldr_if.req;
        eg_l = ldr_if.req && !(both && m_starve == LIMIT);
        eg_c = core_if.req && !eg_l;
        chk("core_gnt", 32'(core_if.gnt), 32'(eg_c));
        chk("ldr_gnt", 32'(ldr_if.gnt), 32'(eg_l));
        chk("mem_wen", 32'(mem_wen), 32'((eg_c && core_if.wen) || (eg_l && ldr_if.wen)));
        chk("mem_addr", mem_addr, eg_c ? core_if.addr : (eg_l ? ldr_if.addr : 32'h0));
        if (eg_c && core_if.wen) chk("mem_wdata_core", mem_wdata, core_if.wdata);
        if (eg_l && ldr_if.wen)  chk("mem_wdata_ldr", mem_wdata, ldr_if.wdata);
        chk("core_rvalid", 32'(core_if.rvalid), 32'(m_cv));
        chk("ldr_rvalid", 32'(ldr_if.rvalid), 32'(m_lv));
        if (m_cv) chk("core_rdata", core_if.rdata, m_cd);
        if (m_lv) chk("ldr_rdata", ldr_if.rdata, m_ld);
        chk("starve_cnt", 32'(dut.r_starve_cnt), 32'(m_starve));

        m_cv = eg_c && !core_if.wen;
        m_cd = shadow[core_if.addr[7:2]];
        m_lv = eg_l && !ldr_if.wen;
        m_ld = shadow[ldr_if.addr[7:2]];
        if (eg_c && core_if.wen) shadow[core_if.addr[7:2]] = core_if.wdata;
        if (eg_l && ldr_if.wen)  shadow[ldr_if.addr[7:2]]  = ldr_if.wdata;
        if (eg_c || !core_if.req) m_starve = 0;
        else if (both && m_starve < LIMIT) m_starve++;
        last_gc = eg_c;
        last_gl = eg_l;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_core(input logic req, input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
        core_if.req = req; core_if.wen = wen; core_if.addr = addr; core_if.wdata = wdata;
    endtask

    task automatic drive_ldr(input logic req, input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
        ldr_if.req = req; ldr_if.wen = wen; ldr_if.addr = addr; ldr_if.wdata = wdata;
    endtask

    int          wen_cycles;
    logic [31:0] grant_pat;

    initial begin
        m_cv = 1'b0; m_lv = 1'b0; m_cd = '0; m_ld = '0; m_starve = 0;
        last_gc = 1'b0; last_gl = 1'b0;
        for (int i = 0; i < 64; i++) shadow[i] = '0;
        rst_n = 1'b0;
        drive_core(1'b0, 1'b0, 32'h0, 32'h0);
        drive_ldr(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        #2;
        chk("rst_core_rvalid", 32'(core_if.rvalid), 32'h0);
        chk("rst_ldr_rvalid", 32'(ldr_if.rvalid), 32'h0);
        @(posedge clk); #1;
        chk("rst_starve", 32'(dut.r_starve_cnt), 32'h0);
        chk("rst_mem_wen", 32'(mem_wen), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;

        // Preload every word through the loader
        for (int i = 0; i < 64; i++) begin
            drive_ldr(1'b1, 1'b1, 32'(i * 4), $urandom);
            tick();
        end
        drive_ldr(1'b1, 1'b1, 32'h0, 32'h11);        tick();
        drive_ldr(1'b1, 1'b1, 32'h4, 32'h22);        tick();
        drive_ldr(1'b1, 1'b1, 32'h40, 32'hDEADBEEF); tick();
        drive_ldr(1'b0, 1'b0, 32'h0, 32'h0);         tick();

        // Core-only load
        drive_core(1'b1, 1'b0, 32'h40, 32'h0);
        #1 chk("core_only_gnt", 32'(core_if.gnt), 32'h1);
        tick();
        chk("core_only_rvalid", 32'(core_if.rvalid), 32'h1);
        chk("core_only_rdata", core_if.rdata, 32'hDEADBEEF);
        chk("core_only_ldr_rvalid", 32'(ldr_if.rvalid), 32'h0);
        drive_core(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Interleaved routing
        drive_ldr(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        chk("ilv_ldr_rvalid", 32'(ldr_if.rvalid), 32'h1);
        chk("ilv_ldr_rdata", ldr_if.rdata, 32'h11);
        chk("ilv_core_rvalid0", 32'(core_if.rvalid), 32'h0);
        drive_ldr(1'b0, 1'b0, 32'h0, 32'h0);
        drive_core(1'b1, 1'b0, 32'h4, 32'h0);
        tick();
        chk("ilv_core_rvalid", 32'(core_if.rvalid), 32'h1);
        chk("ilv_core_rdata", core_if.rdata, 32'h22);
        chk("ilv_ldr_rvalid0", 32'(ldr_if.rvalid), 32'h0);
        drive_core(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Write then read
        wen_cycles = 0;
        drive_ldr(1'b1, 1'b1, 32'h8, 32'hCAFEF00D);
        #1 wen_cycles += int'(mem_wen);
        tick();
        chk("wr_ldr_rvalid", 32'(ldr_if.rvalid), 32'h0);
        drive_ldr(1'b0, 1'b0, 32'h0, 32'h0);
        drive_core(1'b1, 1'b0, 32'h8, 32'h0);
        #1 wen_cycles += int'(mem_wen);
        tick();
        chk("raw_core_rdata", core_if.rdata, 32'hCAFEF00D);
        chk("raw_core_rvalid", 32'(core_if.rvalid), 32'h1);
        drive_core(1'b0, 1'b0, 32'h0, 32'h0);
        #1 wen_cycles += int'(mem_wen);
        tick();
        chk("wen_cycles", 32'(wen_cycles), 32'h1);

        // Contention starvation: expected grants L,L,L,L,C,L,L,L,L,C
        grant_pat = 32'b10_0001_0000;
        drive_core(1'b1, 1'b0, 32'h10, 32'h0);
        drive_ldr(1'b1, 1'b0, 32'h14, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("starve_core_gnt", 32'(core_if.gnt), 32'(grant_pat[i]));
            chk("starve_cnt_seq", 32'(dut.r_starve_cnt), 32'(i % 5));
            tick();
        end

        // Idle
        drive_core(1'b0, 1'b0, 32'h0, 32'h0);
        drive_ldr(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        chk("idle_mem_wen", 32'(mem_wen), 32'h0);
        chk("idle_mem_addr", mem_addr, 32'h0);
        chk("idle_core_rvalid", 32'(core_if.rvalid), 32'h0);
        chk("idle_ldr_rvalid", 32'(ldr_if.rvalid), 32'h0);
        chk("idle_starve", 32'(dut.r_starve_cnt), 32'h0);

        // Random traffic; an ungranted requester holds its request
        for (int n = 0; n < 400; n++) begin
            if (!(core_if.req && !last_gc))
                drive_core($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                           {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)}, $urandom);
            if (!(ldr_if.req && !last_gl))
                drive_ldr($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                          {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)}, $urandom);
            tick();
        end
        drive_core(1'b0, 1'b0, 32'h0, 32'h0);
        drive_ldr(1'b0, 1'b0, 32'h0, 32'h0);
        tick();

        // Async reset mid-read
        drive_core(1'b1, 1'b0, 32'h40, 32'h0);
        tick();
        chk("arst_pre_rvalid", 32'(core_if.rvalid), 32'h1);
        drive_core(1'b1, 1'b0, 32'h4, 32'h0);
        #1 chk("arst_gnt", 32'(core_if.gnt), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid_now", 32'(core_if.rvalid), 32'h0);
        chk("arst_starve", 32'(dut.r_starve_cnt), 32'h0);
        drive_core(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("arst_rvalid_edge", 32'(core_if.rvalid), 32'h0);
        rst_n = 1'b1;
        m_cv = 1'b0; m_lv = 1'b0; m_starve = 0;
        tick();
        chk("arst_rvalid_after", 32'(core_if.rvalid), 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
